// File: rtl/aib_hs_pkg.sv
// Shared types for the AIB 4-phase handshake source controller.
package aib_hs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2,
    ERR     = 2'd3
  } hs_state_e;

  // TIMEOUT value that turns the per-phase watchdog off
  localparam int TIMEOUT_OFF = 0;

endpackage

// File: rtl/aib_bit_sync.sv
// Two-flop synchroniser for signals arriving from another clock domain.
module aib_bit_sync #(
  parameter int                DWIDTH    = 1,
  parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  logic [DWIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aib_hs_sync_tx.sv
// Source side of a 4-phase req/ack word crossing: captures a word, raises req,
// waits for ack high then low, and flags a stalled remote side with a timeout.
module aib_hs_sync_tx
  import aib_hs_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int TO_WIDTH = 10,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DWIDTH-1:0] load_data,
  output logic              load_ready,
  output logic              xfer_req,
  output logic [DWIDTH-1:0] xfer_data,
  input  logic              xfer_ack_async,
  output logic              done,
  output logic              timeout_err,
  input  logic              clear_err
);

  localparam bit                TO_EN   = (TIMEOUT != TIMEOUT_OFF);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TO_EN ? TIMEOUT - 1 : 0);

  hs_state_e           state, state_n;
  logic                req_n, done_n, err_n;
  logic [DWIDTH-1:0]   data_n;
  logic [TO_WIDTH-1:0] cnt, cnt_n;
  logic                ack_s;
  logic                expired;

  aib_bit_sync #(
    .DWIDTH    (1),
    .RESET_VAL (1'b0)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (xfer_ack_async),
    .q     (ack_s)
  );

  // A stale-high ack keeps us from starting a new request on top of it.
  assign load_ready = (state == IDLE) && !ack_s;
  assign expired    = TO_EN && (cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      xfer_req    <= req_n;
      xfer_data   <= data_n;
      done        <= done_n;
      timeout_err <= err_n;
      cnt         <= cnt_n;
    end
  end

  // Counter only advances while staying in a waiting phase; any transition clears it.
  always_comb begin
    state_n = state;
    req_n   = xfer_req;
    data_n  = xfer_data;
    done_n  = 1'b0;
    err_n   = timeout_err;
    cnt_n   = '0;
    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          data_n  = load_data;
          req_n   = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_n   = 1'b0;
          state_n = RELEASE;
        end else if (expired) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ERR: begin
        req_n = 1'b0;
        if (clear_err && !ack_s) begin
          err_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aib_hs_sync_tx.sv
// Bench for aib_hs_sync_tx: directed scenarios with literal expectations, then
// randomized remote behaviour, all compared every cycle against a phase model.
module tb_aib_hs_sync_tx;
  localparam int DW  = 8;
  localparam int TOW = 10;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          clear_err = 1'b0;
  logic          load_ready, xfer_req, done, timeout_err;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack_async;
  logic          ack_echo = 1'b1;
  logic          ack_force = 1'b0;

  int checks = 0;
  int errors = 0;

  assign xfer_ack_async = ack_echo ? xfer_req : ack_force;

  aib_hs_sync_tx #(.DWIDTH(DW), .TO_WIDTH(TOW), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .done           (done),
    .timeout_err    (timeout_err),
    .clear_err      (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting ack high, 2 waiting ack low, 3 error.
  // ack as seen internally is the pin value observed two negedges earlier.
  int            ph = 0, t = 0, e = 0;
  logic [DW-1:0] m_data = '0;
  bit            m_req = 0, m_done = 0, m_err = 0, p1 = 0, p2 = 0;

  always @(negedge clk) begin
    bit ack_now, m_ready, nd;
    if (!rst_n) begin
      ph = 0; t = 0; e = 0; m_data = '0;
      m_req = 0; m_done = 0; m_err = 0; p1 = 0; p2 = 0;
    end
    ack_now = p2;
    m_ready = (ph == 0) && !ack_now;
    chk("outputs{req,done,err,ready,data}",
        {20'd0, xfer_req, done, timeout_err, load_ready, xfer_data},
        {20'd0, m_req, m_done, m_err, m_ready, m_data});
    if (rst_n) begin
      t++;
      nd = 0;
      case (ph)
        0: if (load_valid && m_ready) begin m_data = load_data; m_req = 1; ph = 1; e = t; end
        1: if (ack_now) begin m_req = 0; ph = 2; e = t; end
           else if (TO != 0 && t - e == TO) begin m_req = 0; m_err = 1; ph = 3; e = t; end
        2: if (!ack_now) begin nd = 1; ph = 0; e = t; end
           else if (TO != 0 && t - e == TO) begin m_err = 1; ph = 3; e = t; end
        default: if (clear_err && !ack_now) begin m_err = 0; ph = 0; e = t; end
      endcase
      m_done = nd;
      p2 = p1;
      p1 = xfer_ack_async;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int hi, dn, stall;
    #2;
    chk("reset_req", xfer_req, 0);
    chk("reset_data", xfer_data, 0);
    chk("reset_done_err", {done, timeout_err}, 0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("idle_ready", load_ready, 1);

    // Basic transfer, remote echoes req on ack
    load_valid = 1; load_data = 8'hA5;
    tick();                       // edge 0 accepts; now in cycle 1
    load_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("basic_req_c%0d", k), xfer_req, (k <= 3));
      chk($sformatf("basic_done_c%0d", k), done, (k == 7));
      chk($sformatf("basic_data_c%0d", k), xfer_data, 8'hA5);
      if (k == 7) chk("basic_ready_c7", load_ready, 1);
      tick();
    end

    // Back-to-back: word held valid through done
    load_valid = 1; load_data = 8'h3C;
    tick(7);                      // cycle 7 of first transfer
    chk("b2b_done", done, 1);
    chk("b2b_ready", load_ready, 1);
    tick();
    chk("b2b_req_again", xfer_req, 1);
    chk("b2b_data", xfer_data, 8'h3C);
    load_valid = 0;
    tick(10);

    // Timeout: ack never returned
    ack_echo = 0; ack_force = 0;
    load_valid = 1; load_data = 8'h5A;
    tick();
    load_valid = 0;
    hi = 0; dn = 0;
    for (int k = 0; k < 30; k++) begin
      hi += int'(xfer_req);
      dn += int'(done);
      tick();
    end
    chk("to_req_cycles", hi, 16);
    chk("to_done_count", dn, 0);
    chk("to_err", timeout_err, 1);
    chk("to_ready", load_ready, 0);
    chk("to_req_low", xfer_req, 0);
    chk("to_data_held", xfer_data, 8'h5A);

    // Error recovery: clear with ack high is ignored
    ack_force = 1;
    tick(3);
    clear_err = 1; tick(); clear_err = 0; tick();
    chk("clr_blocked", timeout_err, 1);
    ack_force = 0;
    tick(2);
    clear_err = 1; tick(); clear_err = 0;
    chk("clr_err", timeout_err, 0);
    chk("clr_ready", load_ready, 1);

    // Stuck ack in IDLE
    ack_force = 1;
    tick(3);
    load_valid = 1; load_data = 8'hC3;
    tick(4);
    chk("stuck_ready", load_ready, 0);
    chk("stuck_no_req", xfer_req, 0);
    ack_force = 0;
    tick(2);
    chk("stuck_ready_back", load_ready, 1);
    chk("stuck_still_idle", xfer_req, 0);
    tick();
    chk("stuck_accept", xfer_req, 1);
    chk("stuck_data", xfer_data, 8'hC3);
    load_valid = 0;
    ack_echo = 1;
    tick(10);

    // Reset mid-REQ
    ack_echo = 0; ack_force = 0;
    load_valid = 1; load_data = 8'h77;
    tick(); load_valid = 0; tick();
    chk("rst_pre_req", xfer_req, 1);
    rst_n = 0;
    #1;
    chk("rst_req", xfer_req, 0);
    chk("rst_data", xfer_data, 0);
    chk("rst_done_err", {done, timeout_err}, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    chk("rst_ready", load_ready, 1);

    // Randomized remote: follows req with jitter, occasionally stalls long enough to time out
    stall = 0;
    for (int k = 0; k < 3000; k++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = DW'($urandom);
      clear_err  = ($urandom_range(0, 7) == 0);
      if (stall > 0) stall--;
      else if ($urandom_range(0, 63) == 0) stall = $urandom_range(10, 40);
      else if ($urandom_range(0, 3) != 0) ack_force = xfer_req;
      tick();
    end
    load_valid = 0; clear_err = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
